iurt_fifo_controller: RTL and testbench

IURT_FIFO_CONTROLLER -- requirements
Module: iurt_fifo_controller

---
 rtl/iurt_fifo_controller.sv | 142 ++++++++++++++
 tb/tb_iurt_fifo_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iurt_fifo_controller.sv
// Wishbone-attached byte UART-style FIFO controller: RX FIFO fed from data_dwn,
// TX FIFO drained to data_up, with CTRL/LEVEL registers, break and interrupt.
module iurt_fifo_controller #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        ce,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:2]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o,
  output logic        break_o,
  input  logic        data_dwn_valid,
  input  logic [7:0]  data_dwn,
  output logic        data_dwn_ready,
  input  logic        data_up_ready,
  output logic        data_up_valid,
  output logic [7:0]  data_up
);
  localparam int RA = RX_DEPTH_LOG2;
  localparam int TA = TX_DEPTH_LOG2;

  logic [7:0]  rx_mem [2**RA];
  logic [7:0]  tx_mem [2**TA];
  logic [RA-1:0] rx_wr_q, rx_rd_q;
  logic [TA-1:0] tx_wr_q, tx_rd_q;
  logic [RA:0] rx_lvl_q, rx_lvl_d;
  logic [TA:0] tx_lvl_q, tx_lvl_d;
  logic        ack_q, up_vld_q, ovr_q, ovr_d;
  logic        brk_en_q, brk_en_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, brk_loc_q;
  logic [31:0] dat_q, rdata;
  logic [7:0]  up_q;

  // Level never exceeds depth, so its MSB alone marks full.
  logic rx_full, rx_empty, tx_full, tx_empty;
  assign rx_full  = rx_lvl_q[RA];
  assign tx_full  = tx_lvl_q[TA];
  assign rx_empty = (rx_lvl_q == '0);
  assign tx_empty = (tx_lvl_q == '0);

  logic req, is_data, accept, ctrl_wr, rx_push, rx_pop, tx_push, tx_pop;
  assign req     = cyc_i & stb_i & ~ack_q;
  assign is_data = (adr_i == 2'd0);
  assign accept  = req & ~(we_i & is_data & tx_full);
  assign ctrl_wr = accept & we_i & (adr_i == 2'd1);
  assign rx_pop  = accept & ~we_i & is_data & ~rx_empty;
  assign rx_push = data_dwn_valid & (~rx_full | rx_pop);
  assign tx_push = accept & we_i & is_data;
  assign tx_pop  = data_up_ready & ~tx_empty;

  assign break_o        = brk_loc_q & brk_en_q;
  assign irq_o          = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | ovr_q;
  assign data_dwn_ready = ~rx_full;
  assign ack_o          = ack_q;
  assign dat_o          = dat_q;
  assign data_up_valid  = up_vld_q;
  assign data_up        = up_q;

  always_comb begin
    rdata = '0;
    case (adr_i)
      2'd0: begin
        rdata[9]   = ~tx_full;
        rdata[8]   = ~rx_empty;
        rdata[7:0] = rx_mem[rx_rd_q];
      end
      2'd1:    rdata[3:0] = {ovr_q, tx_ie_q, rx_ie_q, brk_en_q};
      2'd2: begin
        rdata[16 +: TA+1] = tx_lvl_q;
        rdata[0 +: RA+1]  = rx_lvl_q;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    rx_lvl_d = rx_lvl_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_lvl_d = rx_lvl_q + 1'b1;
      2'b01:   rx_lvl_d = rx_lvl_q - 1'b1;
      default: rx_lvl_d = rx_lvl_q;
    endcase
    tx_lvl_d = tx_lvl_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_lvl_d = tx_lvl_q + 1'b1;
      2'b01:   tx_lvl_d = tx_lvl_q - 1'b1;
      default: tx_lvl_d = tx_lvl_q;
    endcase
    ovr_d    = ovr_q | (data_dwn_valid & ~rx_push);
    brk_en_d = break_o ? 1'b0 : brk_en_q;
    rx_ie_d  = rx_ie_q;
    tx_ie_d  = tx_ie_q;
    // A CTRL write overrides both the auto-clear of break_en and overrun setting.
    if (ctrl_wr) begin
      brk_en_d = dat_i[0];
      rx_ie_d  = dat_i[1];
      tx_ie_d  = dat_i[2];
      if (dat_i[3]) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_wr_q <= '0; rx_rd_q <= '0; rx_lvl_q <= '0;
      tx_wr_q <= '0; tx_rd_q <= '0; tx_lvl_q <= '0;
      ack_q <= 1'b0; dat_q <= '0; up_vld_q <= 1'b0; up_q <= '0;
      ovr_q <= 1'b0; brk_en_q <= 1'b1; rx_ie_q <= 1'b0; tx_ie_q <= 1'b0;
      brk_loc_q <= 1'b0;
    end else if (ce) begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      rx_lvl_q  <= rx_lvl_d;
      tx_lvl_q  <= tx_lvl_d;
      ack_q     <= accept;
      if (accept & ~we_i) dat_q <= rdata;
      up_vld_q  <= tx_pop;
      if (tx_pop) up_q <= tx_mem[tx_rd_q];
      ovr_q     <= ovr_d;
      brk_en_q  <= brk_en_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
      brk_loc_q <= data_dwn_valid;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ce && rx_push) rx_mem[rx_wr_q] <= data_dwn;
    if (ce && tx_push) tx_mem[tx_wr_q] <= dat_i[7:0];
  end

  logic unused_dat;
  assign unused_dat = ^dat_i[31:8];
endmodule

// File: tb/tb_iurt_fifo_controller.sv
// Directed self-checking bench for iurt_fifo_controller.
module tb_iurt_fifo_controller;
  logic        clk = 1'b0, arst = 1'b0, ce = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:2]  adr_i = '0;
  logic [31:0] dat_i = '0, dat_o;
  logic        ack_o, irq_o, break_o;
  logic        data_dwn_valid = 1'b0;
  logic [7:0]  data_dwn = '0;
  logic        data_dwn_ready, data_up_ready = 1'b0, data_up_valid;
  logic [7:0]  data_up;

  int checks = 0, errors = 0;
  logic [7:0] upq[$];
  int ack_cnt = 0;
  bit ack_prev = 0, ack_twice = 0;

  iurt_fifo_controller dut (
    .clk(clk), .arst(arst), .ce(ce), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
    .break_o(break_o), .data_dwn_valid(data_dwn_valid), .data_dwn(data_dwn),
    .data_dwn_ready(data_dwn_ready), .data_up_ready(data_up_ready),
    .data_up_valid(data_up_valid), .data_up(data_up)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_up_valid) upq.push_back(data_up);
    if (ack_o) ack_cnt++;
    if (ack_o && ack_prev) ack_twice = 1;
    ack_prev = ack_o;
  end

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic wb_rd(input logic [1:0] a, output logic [31:0] d, output bit ok);
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = a; ok = 0; d = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin ok = 1; d = dat_o; end
    end
    cyc_i = 0; stb_i = 0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] v, input int lim, output bit ok);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = a; dat_i = v; ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(posedge clk); #1;
      if (ack_o) ok = 1;
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic push_dwn(input logic [7:0] b);
    data_dwn_valid = 1; data_dwn = b;
    @(posedge clk); #1;
    data_dwn_valid = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; bit ok;
    arst = 1'b1; #1;
    checks++;
    if (ack_o !== 0 || dat_o !== 0 || data_up_valid !== 0 || data_up !== 0 ||
        data_dwn_ready !== 1 || irq_o !== 0 || break_o !== 0) begin
      errors++; $display("FAIL reset_outputs ack=%b dat=%h uv=%b up=%h rdy=%b irq=%b brk=%b expected 0,0,0,0,1,0,0",
        ack_o, dat_o, data_up_valid, data_up, data_dwn_ready, irq_o, break_o);
    end
    @(posedge clk); #1;
    do_reset();
    wb_rd(2'd1, d, ok);
    checks++; if (!ok || d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got=%h ok=%0d expected 00000001", d, ok); end
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL reset_level got=%h ok=%0d expected 0", d, ok); end
  endtask

  task automatic test_rx_read();
    logic [31:0] d; bit ok;
    do_reset();
    push_dwn(8'h41); push_dwn(8'h42);
    wb_rd(2'd0, d, ok);
    checks++; if (!ok || d !== 32'h341) begin errors++; $display("FAIL rx_read1 got=%h expected 00000341", d); end
    wb_rd(2'd0, d, ok);
    checks++; if (!ok || d !== 32'h342) begin errors++; $display("FAIL rx_read2 got=%h expected 00000342", d); end
    wb_rd(2'd0, d, ok);
    checks++; if (!ok || d[9:8] !== 2'b10) begin errors++; $display("FAIL rx_read_empty got bits9:8=%b expected 10", d[9:8]); end
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL rx_level_after got=%h expected 0", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d; bit ok; int n_ok;
    do_reset();
    upq.delete();
    data_up_ready = 0; n_ok = 0;
    for (int i = 1; i <= 16; i++) begin
      wb_wr(2'd0, 32'(i), 20, ok);
      if (ok) n_ok++;
    end
    checks++; if (n_ok != 16) begin errors++; $display("FAIL tx_acks got=%0d expected 16", n_ok); end
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h0010_0000) begin errors++; $display("FAIL tx_level_full got=%h expected 00100000", d); end
    wb_wr(2'd0, 32'd17, 6, ok);
    checks++; if (ok) begin errors++; $display("FAIL tx_full_withheld got ack=1 expected 0"); end
    data_up_ready = 1;
    wb_wr(2'd0, 32'd17, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_17th_ack got ack=0 expected 1"); end
    repeat (25) @(posedge clk); #1;
    data_up_ready = 0;
    checks++; if (upq.size() != 17) begin errors++; $display("FAIL tx_pulse_count got=%0d expected 17", upq.size()); end
    for (int i = 0; i < 17 && i < upq.size(); i++) begin
      checks++; if (upq[i] !== 8'(i + 1)) begin errors++; $display("FAIL tx_order[%0d] got=%h expected %h", i, upq[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_rx_full();
    logic [31:0] d; bit ok;
    do_reset();
    for (int k = 0; k < 16; k++) push_dwn(8'h10 + 8'(k));
    checks++; if (data_dwn_ready !== 0) begin errors++; $display("FAIL rx_ready_full got=%b expected 0", data_dwn_ready); end
    // pop and push together while full
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 2'd0; data_dwn_valid = 1; data_dwn = 8'h99;
    @(posedge clk); #1;
    data_dwn_valid = 0; cyc_i = 0; stb_i = 0;
    checks++; if (ack_o !== 1 || dat_o !== 32'h310) begin errors++; $display("FAIL rx_pushpop ack=%b dat=%h expected 1 00000310", ack_o, dat_o); end
    wb_rd(2'd1, d, ok);
    checks++; if (!ok || d[3] !== 0) begin errors++; $display("FAIL rx_pushpop_ovr got=%b expected 0", d[3]); end
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h10) begin errors++; $display("FAIL rx_pushpop_level got=%h expected 00000010", d); end
    push_dwn(8'hEE);
    checks++; if (irq_o !== 1) begin errors++; $display("FAIL overrun_irq got=%b expected 1", irq_o); end
    wb_rd(2'd1, d, ok);
    checks++; if (!ok || d !== 32'h8) begin errors++; $display("FAIL overrun_ctrl got=%h expected 00000008", d); end
    wb_wr(2'd1, 32'h8, 20, ok);
    wb_rd(2'd1, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL overrun_clear got=%h expected 0", d); end
    checks++; if (irq_o !== 0) begin errors++; $display("FAIL irq_after_clear got=%b expected 0", irq_o); end
  endtask

  task automatic test_irq_en();
    logic [31:0] d; bit ok;
    do_reset();
    wb_wr(2'd1, 32'h4, 20, ok);
    checks++; if (irq_o !== 1) begin errors++; $display("FAIL tx_empty_irq got=%b expected 1", irq_o); end
    wb_wr(2'd1, 32'h2, 20, ok);
    checks++; if (irq_o !== 0) begin errors++; $display("FAIL rx_irq_idle got=%b expected 0", irq_o); end
    push_dwn(8'h5A);
    checks++; if (irq_o !== 1) begin errors++; $display("FAIL rx_irq got=%b expected 1", irq_o); end
    wb_rd(2'd3, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL adr3_read got=%h expected 0", d); end
  endtask

  task automatic test_break();
    bit ok;
    do_reset();
    data_dwn_valid = 1; data_dwn = 8'h00;
    @(posedge clk); #1;
    data_dwn_valid = 0;
    checks++; if (break_o !== 1) begin errors++; $display("FAIL break_first got=%b expected 1", break_o); end
    @(posedge clk); #1;
    checks++; if (break_o !== 0) begin errors++; $display("FAIL break_one_cycle got=%b expected 0", break_o); end
    push_dwn(8'h01);
    checks++; if (break_o !== 0) begin errors++; $display("FAIL break_disabled got=%b expected 0", break_o); end
    @(posedge clk); #1;
    wb_wr(2'd1, 32'h1, 20, ok);
    push_dwn(8'h02);
    checks++; if (break_o !== 1) begin errors++; $display("FAIL break_rearmed got=%b expected 1", break_o); end
  endtask

  task automatic test_back_to_back();
    int a0;
    do_reset();
    ack_twice = 0; a0 = ack_cnt;
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 2'd2;
    repeat (6) @(posedge clk); #1;
    cyc_i = 0; stb_i = 0;
    @(posedge clk); #1;
    checks++; if (ack_cnt - a0 != 3) begin errors++; $display("FAIL b2b_acks got=%0d expected 3", ack_cnt - a0); end
    checks++; if (ack_twice) begin errors++; $display("FAIL b2b_consecutive got=1 expected 0"); end
  endtask

  task automatic test_ce();
    logic [31:0] d; bit ok; int a0;
    do_reset();
    a0 = ack_cnt;
    ce = 0; data_dwn_valid = 1; data_dwn = 8'h55;
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 2'd2;
    repeat (3) @(posedge clk); #1;
    checks++; if (ack_cnt != a0 || dat_o !== 0 || break_o !== 0 || data_dwn_ready !== 1 || data_up_valid !== 0) begin
      errors++; $display("FAIL ce_hold acks=%0d dat=%h brk=%b rdy=%b uv=%b expected 0,0,0,1,0",
        ack_cnt - a0, dat_o, break_o, data_dwn_ready, data_up_valid);
    end
    data_dwn_valid = 0; cyc_i = 0; stb_i = 0; ce = 1;
    @(posedge clk); #1;
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL ce_no_push got=%h expected 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; bit ok; int a0;
    do_reset();
    for (int i = 0; i < 3; i++) wb_wr(2'd0, 32'(8'hA0 + i), 20, ok);
    for (int i = 0; i < 3; i++) push_dwn(8'hB0 + 8'(i));
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 2'd0;
    @(posedge clk); #1;
    arst = 1; data_up_ready = 1; #1;
    cyc_i = 0; stb_i = 0;
    checks++; if (ack_o !== 0 || data_dwn_ready !== 1) begin errors++; $display("FAIL reset_mid_async ack=%b rdy=%b expected 0 1", ack_o, data_dwn_ready); end
    repeat (2) @(posedge clk); #1;
    upq.delete(); a0 = ack_cnt;
    arst = 0;
    repeat (5) @(posedge clk); #1;
    checks++; if (ack_cnt != a0 || upq.size() != 0) begin errors++; $display("FAIL reset_mid_after acks=%0d pulses=%0d expected 0 0", ack_cnt - a0, upq.size()); end
    data_up_ready = 0;
    wb_rd(2'd2, d, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL reset_mid_levels got=%h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_rx_read();
    test_tx();
    test_rx_full();
    test_irq_en();
    test_break();
    test_back_to_back();
    test_ce();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
